fx_arb: RTL and testbench
=========================

Name: fx_arb

Overview:
- Two-port arbiter and sequencer for the fx register bus.
- Shares the single fx master port between two requesters: port 0 (host command path) and port 1 (internal sequencer).
- Converts each granted request into one fx write or read strobe. For reads, samples the ORed slave return fx_q after a fixed latency and hands the data back to the requester.

Parameters:
- AW, 16, fx address width
- DW, 8, fx data width (fx_q width)
- RD_LAT, 1, cycles from the fx_rd strobe cycle to the cycle in which fx_q is valid; legal range 1..7

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  port 0 request; held high, with m0_we/m0_addr/m0_wdata stable, until m0_gnt
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  AW  target address
- m0_wdata  in  DW  write data
- m0_gnt  out  1  one-cycle accept pulse
- m0_done  out  1  one-cycle completion pulse
- m0_rdata  out  DW  read data, valid with m0_done of a read, held afterwards
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata: identical set for port 1
- fx_a  out  AW  fx address
- fx_data  out  DW  fx write data
- fx_wr  out  1  write strobe, one cycle
- fx_rd  out  1  read strobe, one cycle
- fx_q  in  DW  ORed slave read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - All outputs = 0, including fx_a, fx_data, both rdata ports and busy.
  - Round-robin pointer = 1, so port 0 wins the first tie.
- All outputs are registered.
- IDLE:
  - Arbitration runs every cycle.
  - With a single request, that port wins.
  - With both requesting, the port other than the last granted one wins, and the pointer updates to the winner.
  - At the next edge: latch we/addr/wdata of the winner and move to ISSUE.
- ISSUE (exactly 1 cycle):
  - m<sel>_gnt = 1; fx_a = latched addr.
  - Write: fx_data = wdata and fx_wr = 1; next state DONE.
  - Read: fx_rd = 1; WAIT counter loads RD_LAT; next state WAIT.
  - The requester may change or drop its inputs from the cycle after gnt.
- WAIT:
  - Counter decrements each cycle.
  - If the fx_rd strobe is in cycle t, fx_q is sampled at the end of cycle t+RD_LAT into m<sel>_rdata; then move to DONE.
- DONE (1 cycle):
  - m<sel>_done = 1.
  - Next state IDLE; arbitration for the next request happens in IDLE.
- Timing:
  - Write occupancy: ISSUE + DONE; a back-to-back write costs 3 cycles including IDLE.
  - Read: done appears in cycle t+RD_LAT+1.
- fx_a and fx_data hold their last value outside ISSUE. fx_wr and fx_rd are 0 outside ISSUE.
- m<other>_rdata is never modified by a transaction on the other port.
- A write done leaves rdata unchanged.
- A request that drops before gnt is a requester protocol error. Arbitration uses the current inputs, so a dropped request is simply not granted.
- Simultaneous new requests while busy: ignored until IDLE; requesters keep waiting.
- Reset mid-transaction: abort immediately; no gnt or done issued, and the pointer returns to 1.

Optional Feature:
- Macro FX_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins ties (fixed priority) and the pointer logic is removed.
- Undefined: round-robin as above.

Decomposition:
- Package fx_pkg holds:
  - FX_AW = 16, FX_DW = 8
  - state encoding IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3
- One sub-module, fx_rr_arb2: the 2-way arbiter. Inputs are the two requests, the enable and the pointer; outputs are a one-hot winner and the next pointer. It contains the fixed-priority ifdef.

Test Plan:
- Port-0 write addr 0x0012, data 0xA5: fx_wr = 1 for one cycle with fx_a = 0x0012, fx_data = 0xA5; m0_gnt in the same cycle; m0_done next cycle; m0_rdata unchanged.
- Port-1 read addr 0x0040, RD_LAT = 1, with the slave returning fx_q = 0x3C in cycle t+1: m1_rdata = 0x3C with m1_done in cycle t+2; m0_rdata still 0.
- Both ports request continuously, 4 writes each: grants alternate 0,1,0,1,…; each port gets exactly 4 gnt and 4 done. With FX_ARB_FIXED_PRIO_EN defined, all port-0 grants come first.
- RD_LAT = 3 with fx_q = 0xFF everywhere except 0x5A in cycle t+3: 0x5A is captured; done arrives 4 cycles after the strobe.
- rst_n pulled low during WAIT of a read: all outputs 0 asynchronously; no done after release; next tie grants port 0.
- m0_req drops before grant while port 1 is busy: no port-0 transaction is issued and the fx strobes stay 0.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared constants and FSM state encoding for the fx register-bus arbiter.
package fx_pkg;

  localparam int unsigned FX_AW = 16;
  localparam int unsigned FX_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } fx_state_e;

endpackage

// File: rtl/fx_arb_if.sv
// Bundle of both requester ports plus the shared fx master port.
interface fx_arb_if #(
  parameter int unsigned AW = fx_pkg::FX_AW,
  parameter int unsigned DW = fx_pkg::FX_DW
);

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_done;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_done;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] fx_a;
  logic [DW-1:0] fx_data;
  logic          fx_wr;
  logic          fx_rd;
  logic [DW-1:0] fx_q;
  logic          busy;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_done, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_done, m1_rdata,
    output fx_a, fx_data, fx_wr, fx_rd, busy,
    input  fx_q
  );

  // Requester / slave-model side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_done, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  fx_a, fx_data, fx_wr, fx_rd, busy,
    output fx_q
  );

endinterface

// File: rtl/fx_rr_arb2.sv
// Two-way arbiter: round-robin on ties, or fixed port-0 priority when
// FX_ARB_FIXED_PRIO_EN is defined. ptr_i names the last granted port.
module fx_rr_arb2 (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       en_i,
  input  logic       ptr_i,
  output logic [1:0] win_o,
  output logic       ptr_nxt_o
);

  // Pick a one-hot winner and advance the pointer to it
  always_comb begin
    win_o     = 2'b00;
    ptr_nxt_o = ptr_i;
    if (en_i) begin
      if (req0_i && req1_i) begin
`ifdef FX_ARB_FIXED_PRIO_EN
        win_o = 2'b01;
`else
        win_o = ptr_i ? 2'b01 : 2'b10;
`endif
      end else begin
        win_o = {req1_i, req0_i};
      end
`ifndef FX_ARB_FIXED_PRIO_EN
      if (win_o != 2'b00) ptr_nxt_o = win_o[1];
`endif
    end
  end

endmodule

// File: rtl/fx_arb.sv
// Two-port arbiter/sequencer for the fx register bus. Each grant becomes one
// fx write or read strobe; reads capture fx_q RD_LAT cycles after the strobe.
// Tie policy selectable with FX_ARB_FIXED_PRIO_EN (see fx_rr_arb2).
module fx_arb
  import fx_pkg::*;
#(
  parameter int unsigned AW     = FX_AW,
  parameter int unsigned DW     = FX_DW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk_sys,
  input  logic    rst_n,
  fx_arb_if.slave bus
);

  localparam int unsigned CW = 3;

  fx_state_e     state_q, state_d;
  logic          ptr_q, ptr_d, ptr_nxt;
  logic [1:0]    win;
  logic          sel_q, sel_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [AW-1:0] fx_a_q, fx_a_d;
  logic [DW-1:0] fx_data_q, fx_data_d;
  logic          fx_wr_q, fx_wr_d, fx_rd_q, fx_rd_d;
  logic          busy_q, busy_d;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  fx_rr_arb2 u_arb (
    .req0_i    (bus.m0_req),
    .req1_i    (bus.m1_req),
    .en_i      (state_q == IDLE),
    .ptr_i     (ptr_q),
    .win_o     (win),
    .ptr_nxt_o (ptr_nxt)
  );

  assign w_we    = win[1] ? bus.m1_we    : bus.m0_we;
  assign w_addr  = win[1] ? bus.m1_addr  : bus.m0_addr;
  assign w_wdata = win[1] ? bus.m1_wdata : bus.m0_wdata;

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_nxt;
    sel_d     = sel_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    fx_wr_d   = 1'b0;
    fx_rd_d   = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    fx_a_d    = fx_a_q;
    fx_data_d = fx_data_q;
    case (state_q)
      IDLE: begin
        if (win != 2'b00) begin
          state_d = ISSUE;
          sel_d   = win[1];
          we_d    = w_we;
          fx_a_d  = w_addr;
          if (w_we) fx_data_d = w_wdata;
          fx_wr_d = w_we;
          fx_rd_d = !w_we;
          gnt0_d  = win[0];
          gnt1_d  = win[1];
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
          done0_d = !sel_q;
          done1_d = sel_q;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(RD_LAT);
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          done0_d = !sel_q;
          done1_d = sel_q;
          if (sel_q) rdata1_d = bus.fx_q;
          else       rdata0_d = bus.fx_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, pointer and output registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b1;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      fx_a_q    <= '0;
      fx_data_q <= '0;
      fx_wr_q   <= 1'b0;
      fx_rd_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      fx_a_q    <= fx_a_d;
      fx_data_q <= fx_data_d;
      fx_wr_q   <= fx_wr_d;
      fx_rd_q   <= fx_rd_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.m0_gnt   = gnt0_q;
  assign bus.m1_gnt   = gnt1_q;
  assign bus.m0_done  = done0_q;
  assign bus.m1_done  = done1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.fx_a     = fx_a_q;
  assign bus.fx_data  = fx_data_q;
  assign bus.fx_wr    = fx_wr_q;
  assign bus.fx_rd    = fx_rd_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fx_arb.sv
// Bench for fx_arb: transaction-level timeline model plus table and directed
// sequences. dut_a runs with RD_LAT=1, dut_b with RD_LAT=3.
module tb_fx_arb;
  import fx_pkg::*;

  localparam int unsigned AW    = FX_AW;
  localparam int unsigned DW    = FX_DW;
  localparam int          LAT_A = 1;
  localparam int          LAT_B = 3;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] sval;
    logic [DW-1:0] er0;
    logic [DW-1:0] er1;
  } vec_t;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  fx_arb_if #(.AW(AW), .DW(DW)) bus_a ();
  fx_arb_if #(.AW(AW), .DW(DW)) bus_b ();

  fx_arb #(.AW(AW), .DW(DW), .RD_LAT(LAT_A)) dut_a (
    .clk_sys (clk_sys), .rst_n (rst_n), .bus (bus_a.slave));
  fx_arb #(.AW(AW), .DW(DW), .RD_LAT(LAT_B)) dut_b (
    .clk_sys (clk_sys), .rst_n (rst_n), .bus (bus_b.slave));

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // requester drivers
  txn_t pq[2][$];
  txn_t cur[2];
  bit   act[2];
  bit   gseen[2];
  int   spur_cnt;

  // timeline model
  bit            inflight;
  int            g_cyc, d_cyc, idle_from, wport, last;
  txn_t          wtxn;
  logic [DW-1:0] pend_rd;
  logic [DW-1:0] exp_rd[2];
  logic [AW-1:0] exp_a;
  logic [DW-1:0] exp_d;

  // slave model and observations
  logic [DW-1:0] mem [int];
  int            due;
  logic [DW-1:0] due_val;
  int            gnt_cnt[2], done_cnt[2], strobe_cnt;
  int            gnt_order[$];
  logic [AW-1:0] obs_a;
  logic          obs_we;
  logic [DW-1:0] obs_d;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, act_v, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] slave_val(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return DW'(a) ^ DW'(a >> 8) ^ 8'h96;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = AW'($urandom);
    t.wdata = DW'($urandom);
    return t;
  endfunction

  function automatic bit all_idle();
    return pq[0].size() == 0 && pq[1].size() == 0 && !act[0] && !act[1] &&
           !gseen[0] && !gseen[1] && !inflight;
  endfunction

  // One cycle: slave response, per-cycle checks, requester update, prediction
  task automatic step();
    logic is_g, is_d, r0, r1;
    @(negedge clk_sys);
    cyc++;
    bus_a.fx_q = (cyc == due) ? due_val : DW'($urandom);
    if (bus_a.fx_rd === 1'b1) begin
      due     = cyc + LAT_A;
      due_val = slave_val(bus_a.fx_a);
    end
    if (bus_a.fx_wr === 1'b1 || bus_a.fx_rd === 1'b1) begin
      strobe_cnt++;
      obs_a  = bus_a.fx_a;
      obs_we = bus_a.fx_wr;
      obs_d  = bus_a.fx_data;
    end
    is_g = inflight && cyc == g_cyc;
    is_d = inflight && cyc == d_cyc;
    if (is_g) begin
      exp_a = wtxn.addr;
      if (wtxn.we) exp_d = wtxn.wdata;
    end
    if (is_d && !wtxn.we) exp_rd[wport] = pend_rd;
    chk("m0_gnt",   32'(bus_a.m0_gnt),   32'(is_g && wport == 0));
    chk("m1_gnt",   32'(bus_a.m1_gnt),   32'(is_g && wport == 1));
    chk("fx_wr",    32'(bus_a.fx_wr),    32'(is_g && wtxn.we));
    chk("fx_rd",    32'(bus_a.fx_rd),    32'(is_g && !wtxn.we));
    chk("fx_a",     32'(bus_a.fx_a),     32'(exp_a));
    chk("fx_data",  32'(bus_a.fx_data),  32'(exp_d));
    chk("m0_done",  32'(bus_a.m0_done),  32'(is_d && wport == 0));
    chk("m1_done",  32'(bus_a.m1_done),  32'(is_d && wport == 1));
    chk("m0_rdata", 32'(bus_a.m0_rdata), 32'(exp_rd[0]));
    chk("m1_rdata", 32'(bus_a.m1_rdata), 32'(exp_rd[1]));
    chk("busy",     32'(bus_a.busy),     32'(inflight && cyc >= g_cyc && cyc <= d_cyc));
    if (bus_a.m0_gnt === 1'b1) begin gnt_cnt[0]++; gnt_order.push_back(0); end
    if (bus_a.m1_gnt === 1'b1) begin gnt_cnt[1]++; gnt_order.push_back(1); end
    if (bus_a.m0_done === 1'b1) done_cnt[0]++;
    if (bus_a.m1_done === 1'b1) done_cnt[1]++;
    if (is_d) inflight = 1'b0;

    for (int p = 0; p < 2; p++) begin
      if ((p == 0 ? bus_a.m0_gnt : bus_a.m1_gnt) === 1'b1) gseen[p] = 1'b1;
      else if (gseen[p]) begin
        gseen[p] = 1'b0;
        act[p]   = 1'b0;
      end
      if (!act[p] && pq[p].size() > 0) begin
        cur[p] = pq[p].pop_front();
        act[p] = 1'b1;
      end
    end
    r0 = act[0] || (spur_cnt > 0);
    r1 = act[1];
    if (spur_cnt > 0) spur_cnt--;
    bus_a.m0_req = r0; bus_a.m0_we = cur[0].we; bus_a.m0_addr = cur[0].addr; bus_a.m0_wdata = cur[0].wdata;
    bus_a.m1_req = r1; bus_a.m1_we = cur[1].we; bus_a.m1_addr = cur[1].addr; bus_a.m1_wdata = cur[1].wdata;

    if (rst_n && !inflight && cyc >= idle_from && (r0 || r1)) begin
      if (r0 && r1) begin
`ifdef FX_ARB_FIXED_PRIO_EN
        wport = 0;
`else
        wport = (last == 1) ? 0 : 1;
`endif
      end else begin
        wport = r0 ? 0 : 1;
      end
      last      = wport;
      wtxn      = cur[wport];
      g_cyc     = cyc + 1;
      d_cyc     = g_cyc + (wtxn.we ? 1 : LAT_A + 1);
      idle_from = d_cyc + 1;
      pend_rd   = slave_val(wtxn.addr);
      inflight  = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst strobes", 32'({bus_a.m0_gnt, bus_a.m1_gnt, bus_a.m0_done, bus_a.m1_done,
                            bus_a.fx_wr, bus_a.fx_rd, bus_a.busy}), 32'(0));
    chk("rst fx_a",    32'(bus_a.fx_a),     32'(0));
    chk("rst fx_data", 32'(bus_a.fx_data),  32'(0));
    chk("rst rdata0",  32'(bus_a.m0_rdata), 32'(0));
    chk("rst rdata1",  32'(bus_a.m1_rdata), 32'(0));
    inflight = 1'b0; last = 1; idle_from = 0; due = -1;
    exp_a = '0; exp_d = '0; exp_rd[0] = '0; exp_rd[1] = '0;
    spur_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      pq[p].delete();
      act[p] = 1'b0; gseen[p] = 1'b0;
      cur[p] = '{1'b0, '0, '0};
    end
    bus_a.m0_req = 1'b0; bus_a.m1_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (all_idle()) break;
      step();
    end
    chk("drain", 32'(all_idle()), 32'(1));
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   s0, st, tb, db, d0;
    int   exp_o[8];

    tbl[0] = '{0, 1'b1, 16'h0012, 8'hA5, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{1, 1'b0, 16'h0040, 8'h00, 8'h3C, 8'h00, 8'h3C};
    tbl[2] = '{0, 1'b0, 16'h1234, 8'h00, 8'h77, 8'h77, 8'h3C};
    tbl[3] = '{1, 1'b1, 16'h0040, 8'h5A, 8'h00, 8'h77, 8'h3C};
    tbl[4] = '{1, 1'b0, 16'hFFFF, 8'h00, 8'h00, 8'h77, 8'h00};
    tbl[5] = '{0, 1'b1, 16'h0000, 8'hFF, 8'h00, 8'h77, 8'h00};
    tbl[6] = '{0, 1'b0, 16'h8001, 8'h00, 8'hC3, 8'hC3, 8'h00};
    tbl[7] = '{1, 1'b0, 16'h0001, 8'h00, 8'h81, 8'hC3, 8'h81};

    bus_a.fx_q = '0;
    bus_b.m0_req = 1'b0; bus_b.m0_we = 1'b0; bus_b.m0_addr = '0; bus_b.m0_wdata = '0;
    bus_b.m1_req = 1'b0; bus_b.m1_we = 1'b0; bus_b.m1_addr = '0; bus_b.m1_wdata = '0;
    bus_b.fx_q = '0;
    #2;
    do_reset();

    // Table of single transactions
    for (int i = 0; i < 8; i++) begin
      txn_t t;
      t.we = tbl[i].we; t.addr = tbl[i].addr; t.wdata = tbl[i].wdata;
      if (!tbl[i].we) mem[int'(tbl[i].addr)] = tbl[i].sval;
      pq[tbl[i].port].push_back(t);
      drain();
      chk("tbl strobe addr", 32'(obs_a), 32'(tbl[i].addr));
      chk("tbl strobe kind", 32'(obs_we), 32'(tbl[i].we));
      if (tbl[i].we) chk("tbl wdata", 32'(obs_d), 32'(tbl[i].wdata));
      chk("tbl rdata0", 32'(bus_a.m0_rdata), 32'(tbl[i].er0));
      chk("tbl rdata1", 32'(bus_a.m1_rdata), 32'(tbl[i].er1));
    end

    // Port-0 request raised and dropped while port 1 is busy
    s0 = gnt_cnt[0]; st = strobe_cnt;
    pq[1].push_back('{1'b0, 16'h0040, 8'h00});
    step();
    spur_cnt = 3;
    drain();
    repeat (3) step();
    chk("spur gnt0", 32'(gnt_cnt[0] - s0), 32'(0));
    chk("spur strobes", 32'(strobe_cnt - st), 32'(1));

    // Both ports request continuously, 4 writes each
    do_reset();
    gnt_order.delete();
    gnt_cnt[0] = 0; gnt_cnt[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
    for (int k = 0; k < 4; k++) begin
      pq[0].push_back('{1'b1, AW'(16'h0100 + k), DW'(8'h10 + k)});
      pq[1].push_back('{1'b1, AW'(16'h0200 + k), DW'(8'h20 + k)});
    end
    drain();
    chk("rr gnt0 count",  32'(gnt_cnt[0]),  32'(4));
    chk("rr gnt1 count",  32'(gnt_cnt[1]),  32'(4));
    chk("rr done0 count", 32'(done_cnt[0]), 32'(4));
    chk("rr done1 count", 32'(done_cnt[1]), 32'(4));
`ifdef FX_ARB_FIXED_PRIO_EN
    exp_o = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_o = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    chk("rr order size", 32'(gnt_order.size()), 32'(8));
    for (int k = 0; k < 8 && k < gnt_order.size(); k++)
      chk("rr order", 32'(gnt_order[k]), 32'(exp_o[k]));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 3) == 0 && pq[p].size() < 2) pq[p].push_back(rand_txn());
      step();
    end
    drain();

    // RD_LAT=3 capture window on dut_b
    bus_b.m0_we = 1'b0; bus_b.m0_addr = 16'h0ABC; bus_b.m0_req = 1'b1;
    tb = -1; db = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      bus_b.fx_q = 8'hFF;
      if (bus_b.m0_gnt === 1'b1) begin tb = cyc; break; end
    end
    chk("b gnt seen", 32'(tb >= 0), 32'(1));
    chk("b fx_rd", 32'(bus_b.fx_rd), 32'(1));
    chk("b fx_a", 32'(bus_b.fx_a), 32'(16'h0ABC));
    for (int i = 0; i < 12; i++) begin
      step();
      if (cyc == tb + 1) bus_b.m0_req = 1'b0;
      bus_b.fx_q = (cyc == tb + LAT_B) ? 8'h5A : 8'hFF;
      if (bus_b.m0_done === 1'b1) begin db = cyc; break; end
    end
    bus_b.m0_req = 1'b0;
    chk("b done latency", 32'(db - tb), 32'(LAT_B + 1));
    chk("b rdata0", 32'(bus_b.m0_rdata), 32'(8'h5A));
    chk("b rdata1", 32'(bus_b.m1_rdata), 32'(0));

    // Reset while a port-0 read sits in WAIT
    do_reset();
    pq[0].push_back('{1'b0, 16'h0777, 8'h00});
    tb = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (inflight && cyc == g_cyc + 1) begin tb = 1; break; end
    end
    chk("mid reach wait", 32'(tb), 32'(1));
    chk("mid busy", 32'(bus_a.busy), 32'(1));
    d0 = done_cnt[0];
    do_reset();
    repeat (5) step();
    chk("mid no done", 32'(done_cnt[0] - d0), 32'(0));
    gnt_order.delete();
    pq[0].push_back('{1'b1, 16'h0300, 8'h33});
    pq[1].push_back('{1'b1, 16'h0301, 8'h44});
    drain();
    chk("tie size", 32'(gnt_order.size()), 32'(2));
    if (gnt_order.size() > 0) chk("tie first", 32'(gnt_order[0]), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
